// File: rtl/hack_screen_pkg.sv
// Shared constants and types for the screen reader: screen geometry and
// the fetch-side state encoding.
package hack_screen_pkg;

    localparam int SCREEN_BASE   = 16384;
    localparam int SCREEN_WORDS  = 8192;
    localparam int WORDS_PER_ROW = 32;
    localparam int ROWS          = 256;

    localparam int ADDR_W = 15;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/hack_screen_reader_if.sv
// RAM read port and pixel stream of the screen reader, grouped as one bundle.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// (mem_req && mem_gnt for the address, pix_valid && pix_ready for a pixel).
// Once valid is high it stays high with its payload stable until that transfer.
interface hack_screen_reader_if;
    import hack_screen_pkg::*;

    logic              mem_req;
    logic              mem_gnt;
    logic [0:ADDR_W-1] mem_address;
    logic              mem_load;
    logic [0:WORD_W-1] mem_out;

    logic              pix;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_sol;
    logic              pix_eof;

    modport master (
        output mem_req, mem_address, mem_load,
        output pix, pix_valid, pix_sol, pix_eof,
        input  mem_gnt, mem_out, pix_ready
    );

    modport slave (
        input  mem_req, mem_address, mem_load,
        input  pix, pix_valid, pix_sol, pix_eof,
        output mem_gnt, mem_out, pix_ready
    );

endinterface

// File: rtl/hack_word_fifo2.sv
// Two-entry word buffer between the RAM read data and the pixel shifter.
// Push when full and pop when empty are dropped.
module hack_word_fifo2
    import hack_screen_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [0:WORD_W-1] din,
    output logic [0:WORD_W-1] head,
    output logic [1:0]        count
);

    logic [0:WORD_W-1] mem_q [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);
    assign head    = mem_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr] <= din;
                wr_ptr        <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hack_screen_reader.sv
// Walks the screen region of the data RAM once per start and streams it out
// one pixel per cycle, leftmost pixel (index 15 of each word) first.
module hack_screen_reader
    import hack_screen_pkg::*;
#(
    parameter int BASE_ADDR     = hack_screen_pkg::SCREEN_BASE,
    parameter int WORDS_PER_ROW = hack_screen_pkg::WORDS_PER_ROW,
    parameter int ROWS          = hack_screen_pkg::ROWS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output fetch_state_e         dbg_state,
    hack_screen_reader_if.master bus
);

    localparam logic [14:0] BASE_W    = 15'(BASE_ADDR);
    localparam logic [12:0] LAST_WORD = 13'(WORDS_PER_ROW * ROWS - 1);
    localparam logic [4:0]  COL_LAST  = 5'(WORDS_PER_ROW - 1);
    localparam logic [7:0]  ROW_LAST  = 8'(ROWS - 1);

    fetch_state_e state_q;
    fetch_state_e state_d;

    logic [12:0]       word_cnt;
    logic [3:0]        bit_idx;
    logic [4:0]        col_cnt;
    logic [7:0]        row_cnt;
    logic [0:WORD_W-1] sh_word;
    logic              sh_valid;
    logic              inflight;
    logic              done_q;

    logic [1:0]        fifo_count;
    logic [0:WORD_W-1] fifo_head;

    logic start_ok;
    logic room;
    logic req;
    logic consume;
    logic last_bit;
    logic accept;
    logic at_eof;
    logic word_done;
    logic load;

    // A read is only issued when its data is guaranteed a FIFO slot on return.
    assign room      = ({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2;
    assign start_ok  = (state_q == IDLE) && start;
    assign consume   = req && bus.mem_gnt;
    assign last_bit  = (bit_idx == 4'd15);
    assign accept    = sh_valid && bus.pix_ready;
    assign at_eof    = sh_valid && last_bit && (col_cnt == COL_LAST) && (row_cnt == ROW_LAST);
    assign word_done = accept && last_bit;
    // Refill on the same edge the final bit leaves, so words stream back to back.
    assign load      = (fifo_count != 2'd0) && (!sh_valid || word_done);

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = FETCH;
            end
            FETCH: begin
                req = room;
                if (consume && (word_cnt == LAST_WORD)) state_d = DRAIN;
            end
            DRAIN: begin
                if (accept && at_eof) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_cnt <= '0;
            bit_idx  <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
            sh_word  <= '0;
            sh_valid <= 1'b0;
            inflight <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            inflight <= consume;
            done_q   <= accept && at_eof;
            if (start_ok) begin
                word_cnt <= '0;
                bit_idx  <= '0;
                col_cnt  <= '0;
                row_cnt  <= '0;
                sh_valid <= 1'b0;
            end else begin
                if (consume) word_cnt <= word_cnt + 13'd1;
                if (accept) begin
                    bit_idx <= bit_idx + 4'd1;
                    if (last_bit) begin
                        col_cnt <= (col_cnt == COL_LAST) ? 5'd0 : col_cnt + 5'd1;
                        if (col_cnt == COL_LAST) begin
                            row_cnt <= (row_cnt == ROW_LAST) ? 8'd0 : row_cnt + 8'd1;
                        end
                    end
                end
                if (load) begin
                    sh_word  <= fifo_head;
                    sh_valid <= 1'b1;
                end else if (word_done) begin
                    sh_valid <= 1'b0;
                end
            end
        end
    end

    // Read data is registered in the RAM, so it is captured one cycle after
    // the address was consumed, which is exactly while inflight is set.
    hack_word_fifo2 u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight),
        .pop   (load),
        .din   (bus.mem_out),
        .head  (fifo_head),
        .count (fifo_count)
    );

    assign bus.mem_req     = req;
    assign bus.mem_address = (state_q == FETCH) ? (BASE_W + {2'b00, word_cnt}) : 15'd0;
    assign bus.mem_load    = 1'b0;
    assign bus.pix         = sh_valid & sh_word[4'd15 - bit_idx];
    assign bus.pix_valid   = sh_valid;
    assign bus.pix_sol     = sh_valid && (col_cnt == 5'd0) && (bit_idx == 4'd0);
    assign bus.pix_eof     = at_eof;

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule
